// File: rtl/vx_cta_dispatcher_pkg.sv
// Shared types and sizing for the CTA dispatcher and its credit pool.
package vx_cta_dispatcher_pkg;

  localparam int unsigned CTA_DATA_W     = 128;
  localparam int unsigned WARPS_PER_CORE = 8;
  localparam int unsigned WCNT_W         = $clog2(WARPS_PER_CORE + 1);
  localparam int unsigned INFL_W         = 16;

  typedef enum logic [1:0] {CTA_IDLE, CTA_SELECT, CTA_SEND} cta_state_e;

  typedef struct packed {
    logic [CTA_DATA_W-1:0] data;
    logic [31:0]           warps;
    logic                  last;
  } cta_req_t;

  // A CTA declaring zero warps still occupies one slot.
  function automatic logic [31:0] eff_warps(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/vx_cta_credit_pool.sv
// Per-core free warp-slot counters with allocate/release and a fits vector.
module vx_cta_credit_pool
  import vx_cta_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_valid,
  input  logic [IDX_W-1:0]            alloc_core,
  input  logic [WCNT_W-1:0]           alloc_warps,
  input  logic [NUM_CORES-1:0]        release_valid,
  input  logic [NUM_CORES*WCNT_W-1:0] release_warps,
  input  logic [WCNT_W-1:0]           req_warps,
  output logic [NUM_CORES-1:0]        fits_c
);

  localparam int unsigned SUM_W = WCNT_W + 1;

  logic [NUM_CORES-1:0][WCNT_W-1:0] credit;
  logic [SUM_W-1:0]                 sum_c [NUM_CORES];

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      fits_c[i] = (credit[i] >= req_warps);
      sum_c[i]  = SUM_W'(credit[i])
                + (release_valid[i] ? SUM_W'(release_warps[i*WCNT_W +: WCNT_W]) : SUM_W'(0))
                - ((alloc_valid && (alloc_core == IDX_W'(i))) ? SUM_W'(alloc_warps) : SUM_W'(0));
    end
  end

  // Allocation and release on the same core in one cycle net out; overflow saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) credit[i] <= WCNT_W'(WARPS_PER_CORE);
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        assert (sum_c[i] <= SUM_W'(WARPS_PER_CORE));
        credit[i] <= (sum_c[i] > SUM_W'(WARPS_PER_CORE)) ? WCNT_W'(WARPS_PER_CORE)
                                                        : WCNT_W'(sum_c[i]);
      end
    end
  end

endmodule

// File: rtl/vx_cta_dispatcher.sv
// Hands KMU CTAs to cores round-robin by free warp slots; flags kernel completion.
module vx_cta_dispatcher
  import vx_cta_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cta_in_valid,
  output logic                        cta_in_ready,
  input  logic [CTA_DATA_W-1:0]       cta_in_data,
  input  logic [31:0]                 cta_in_warps,
  input  logic                        cta_in_last,
  output logic [NUM_CORES-1:0]        cta_out_valid,
  input  logic [NUM_CORES-1:0]        cta_out_ready,
  output logic [CTA_DATA_W-1:0]       cta_out_data,
  input  logic [NUM_CORES-1:0]        cta_done_valid,
  input  logic [NUM_CORES*WCNT_W-1:0] cta_done_warps,
  output logic                        busy,
  output logic                        kernel_done,
  output logic                        error
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  cta_state_e            state;
  cta_req_t              req;
  logic [IDX_W-1:0]      sel_core;
  logic [IDX_W-1:0]      rr_ptr;
  logic [INFL_W-1:0]     inflight;
  logic                  last_seen;

  logic [NUM_CORES-1:0]  fits_c;
  logic [NUM_CORES-1:0]  rot_c;
  logic [IDX_W-1:0]      off_c;
  logic [IDX_W-1:0]      pick_core_c;
  logic                  pick_found_c;
  logic                  too_big_c;
  logic                  in_hs_c;
  logic                  out_hs_c;
  logic                  go_idle_c;
  logic [INFL_W-1:0]     done_cnt_c;
  logic [INFL_W-1:0]     infl_up_c;
  logic [INFL_W-1:0]     inflight_nxt_c;

  vx_cta_credit_pool #(.NUM_CORES(NUM_CORES)) u_credit_pool (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid   (out_hs_c),
    .alloc_core    (sel_core),
    .alloc_warps   (WCNT_W'(req.warps)),
    .release_valid (cta_done_valid),
    .release_warps (cta_done_warps),
    .req_warps     (WCNT_W'(req.warps)),
    .fits_c        (fits_c)
  );

  // Rotate the fits vector so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot_c        = '0;
    off_c        = '0;
    pick_found_c = 1'b0;
    for (int i = 0; i < NUM_CORES; i++)
      rot_c[i] = fits_c[IDX_W'((32'(rr_ptr) + 32'(i)) % NUM_CORES)];
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rot_c[i]) begin
        pick_found_c = 1'b1;
        off_c        = IDX_W'(i);
      end
    end
    pick_core_c = IDX_W'((32'(rr_ptr) + 32'(off_c)) % NUM_CORES);
  end

  always_comb begin
    too_big_c  = (req.warps > 32'(WARPS_PER_CORE));
    in_hs_c    = (state == CTA_IDLE) && cta_in_valid && cta_in_ready;
    out_hs_c   = (state == CTA_SEND) && cta_out_ready[sel_core];
    go_idle_c  = ((state == CTA_IDLE) && !in_hs_c)
              || ((state == CTA_SELECT) && too_big_c)
              || ((state == CTA_SEND) && out_hs_c);
    done_cnt_c = '0;
    for (int i = 0; i < NUM_CORES; i++)
      done_cnt_c = done_cnt_c + INFL_W'(cta_done_valid[i]);
    infl_up_c      = inflight + INFL_W'(out_hs_c);
    inflight_nxt_c = (infl_up_c < done_cnt_c) ? '0 : (infl_up_c - done_cnt_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CTA_IDLE;
      req           <= '0;
      sel_core      <= '0;
      rr_ptr        <= '0;
      inflight      <= '0;
      last_seen     <= 1'b0;
      cta_in_ready  <= 1'b0;
      cta_out_valid <= '0;
      cta_out_data  <= '0;
      busy          <= 1'b0;
      kernel_done   <= 1'b0;
      error         <= 1'b0;
    end else begin
      assert (infl_up_c >= done_cnt_c);
      inflight     <= inflight_nxt_c;
      cta_in_ready <= go_idle_c;
      busy         <= !go_idle_c || (inflight_nxt_c != '0);
      kernel_done  <= 1'b0;
      if ((state == CTA_IDLE) && last_seen && (inflight == '0)) begin
        kernel_done <= 1'b1;
        last_seen   <= 1'b0;
      end
      case (state)
        CTA_IDLE: begin
          if (in_hs_c) begin
            req   <= '{data: cta_in_data, warps: eff_warps(cta_in_warps), last: cta_in_last};
            state <= CTA_SELECT;
          end
        end
        CTA_SELECT: begin
          if (too_big_c) begin
            error <= 1'b1;
            if (req.last) last_seen <= 1'b1;
            state <= CTA_IDLE;
          end else if (pick_found_c) begin
            sel_core      <= pick_core_c;
            cta_out_valid <= NUM_CORES'(1) << pick_core_c;
            cta_out_data  <= req.data;
            state         <= CTA_SEND;
          end
        end
        CTA_SEND: begin
          if (out_hs_c) begin
            cta_out_valid <= '0;
            rr_ptr        <= (sel_core == IDX_W'(NUM_CORES - 1)) ? '0 : sel_core + IDX_W'(1);
            if (req.last) last_seen <= 1'b1;
            state         <= CTA_IDLE;
          end
        end
        default: state <= CTA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_cta_dispatcher.sv
// Directed bench for the CTA dispatcher with hand-computed expectations.
module tb_vx_cta_dispatcher;
  import vx_cta_dispatcher_pkg::*;

  localparam int unsigned NC = 4;

  logic                   clk;
  logic                   reset;
  logic                   cta_in_valid;
  logic                   cta_in_ready;
  logic [CTA_DATA_W-1:0]  cta_in_data;
  logic [31:0]            cta_in_warps;
  logic                   cta_in_last;
  logic [NC-1:0]          cta_out_valid;
  logic [NC-1:0]          cta_out_ready;
  logic [CTA_DATA_W-1:0]  cta_out_data;
  logic [NC-1:0]          cta_done_valid;
  logic [NC*WCNT_W-1:0]   cta_done_warps;
  logic                   busy;
  logic                   kernel_done;
  logic                   error;

  int total;
  int bad;

  vx_cta_dispatcher #(.NUM_CORES(NC)) dut (
    .clk            (clk),
    .reset          (reset),
    .cta_in_valid   (cta_in_valid),
    .cta_in_ready   (cta_in_ready),
    .cta_in_data    (cta_in_data),
    .cta_in_warps   (cta_in_warps),
    .cta_in_last    (cta_in_last),
    .cta_out_valid  (cta_out_valid),
    .cta_out_ready  (cta_out_ready),
    .cta_out_data   (cta_out_data),
    .cta_done_valid (cta_done_valid),
    .cta_done_warps (cta_done_warps),
    .busy           (busy),
    .kernel_done    (kernel_done),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pay(input int k);
    return {96'h5eed_0000_0000_0000_0000_0000, 32'hA000_0000 + 32'(k)};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push(input int k, input int w, input logic last);
    int n;
    n = 0;
    while (!cta_in_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("push_ready", cta_in_ready, 1);
    cta_in_valid = 1'b1;
    cta_in_data  = pay(k);
    cta_in_warps = 32'(w);
    cta_in_last  = last;
    tick();
    cta_in_valid = 1'b0;
    cta_in_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int core, input int k);
    int n;
    n = 0;
    while (cta_out_valid == '0 && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_vld"}, cta_out_valid, NC'(1) << core);
    check_eq({tag, "_data"}, cta_out_data, pay(k));
  endtask

  task automatic retire(input int core, input int w);
    cta_done_valid = NC'(1) << core;
    cta_done_warps = (NC*WCNT_W)'(w) << (core * WCNT_W);
    tick();
    cta_done_valid = '0;
    cta_done_warps = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_rdy"}, cta_in_ready, 0);
    check_eq({tag, "_out_vld"}, cta_out_valid, 0);
    check_eq({tag, "_out_data"}, cta_out_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_kdone"}, kernel_done, 0);
    check_eq({tag, "_err"}, error, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    cta_in_valid = 1'b0;
    cta_in_data = '0;
    cta_in_warps = '0;
    cta_in_last = 1'b0;
    cta_out_ready = '0;
    cta_done_valid = '0;
    cta_done_warps = '0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check_eq("idle_ready", cta_in_ready, 1);

    // 4 full-size CTAs fill cores 0..3; the 5th waits for core 2 to retire.
    cta_out_ready = 4'hF;
    push(0, 8, 1'b0);
    check_eq("lat_1", cta_out_valid, 0);
    tick();
    check_eq("lat_2", cta_out_valid, 4'b0001);
    check_eq("lat_data", cta_out_data, pay(0));
    for (int k = 1; k < 4; k++) begin
      push(k, 8, 1'b0);
      expect_out("t1_rr", k, k);
    end
    push(4, 8, 1'b0);
    repeat (4) tick();
    check_eq("t1_stall_vld", cta_out_valid, 0);
    check_eq("t1_stall_rdy", cta_in_ready, 0);
    check_eq("t1_stall_busy", busy, 1);
    retire(2, 8);
    check_eq("t1_c2_back", dut.u_credit_pool.credit[2], 8);
    check_eq("t1_old_credit", cta_out_valid, 0);
    expect_out("t1_5th", 2, 4);
    tick();
    check_eq("t1_c2_used", dut.u_credit_pool.credit[2], 0);

    // Small CTAs spread round-robin; a stalled core sees stable valid/data.
    do_reset();
    cta_out_ready = 4'b1110;
    push(10, 3, 1'b0);
    expect_out("t2_a", 0, 10);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("t2_hold_vld", cta_out_valid, 4'b0001);
      check_eq("t2_hold_data", cta_out_data, pay(10));
    end
    cta_out_ready = 4'hF;
    tick();
    check_eq("t2_c0", dut.u_credit_pool.credit[0], 5);
    push(11, 3, 1'b0);
    expect_out("t2_b", 1, 11);
    push(12, 3, 1'b0);
    expect_out("t2_c", 2, 12);
    tick();
    check_eq("t2_c2", dut.u_credit_pool.credit[2], 5);
    check_eq("t2_c3", dut.u_credit_pool.credit[3], 8);

    // Oversized CTA is dropped with sticky error.
    push(13, 9, 1'b0);
    check_eq("t3_rdy_low", cta_in_ready, 0);
    tick();
    check_eq("t3_err", error, 1);
    check_eq("t3_rdy_back", cta_in_ready, 1);
    check_eq("t3_no_vld", cta_out_valid, 0);

    // Zero-warp CTA takes one slot (rr pointer now at core 3).
    push(14, 0, 1'b0);
    expect_out("t4", 3, 14);
    tick();
    check_eq("t4_c3", dut.u_credit_pool.credit[3], 7);
    check_eq("t4_err_sticky", error, 1);

    // Credit freed in the cycle SELECT is evaluating is used one cycle later.
    do_reset();
    cta_out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      push(20 + k, 8, 1'b0);
      expect_out("t5_fill", k, 20 + k);
    end
    tick();
    push(24, 4, 1'b0);
    repeat (3) tick();
    check_eq("t5_wait", cta_out_valid, 0);
    retire(1, 4);
    check_eq("t5_no_bypass", cta_out_valid, 0);
    check_eq("t5_c1_4", dut.u_credit_pool.credit[1], 4);
    tick();
    check_eq("t5_vld", cta_out_valid, 4'b0010);
    check_eq("t5_data", cta_out_data, pay(24));
    tick();
    check_eq("t5_c1_0", dut.u_credit_pool.credit[1], 0);
    check_eq("t5_vld_off", cta_out_valid, 0);

    // Two-CTA kernel: kernel_done pulses once after both retire.
    do_reset();
    cta_out_ready = 4'hF;
    push(30, 2, 1'b0);
    expect_out("t6_a", 0, 30);
    push(31, 2, 1'b1);
    expect_out("t6_b", 1, 31);
    tick();
    check_eq("t6_kd_early", kernel_done, 0);
    check_eq("t6_busy_infl", busy, 1);
    retire(0, 2);
    check_eq("t6_kd_one_left", kernel_done, 0);
    check_eq("t6_busy_one_left", busy, 1);
    retire(1, 2);
    check_eq("t6_busy_clear", busy, 0);
    check_eq("t6_kd_pre", kernel_done, 0);
    tick();
    check_eq("t6_kd_pulse", kernel_done, 1);
    tick();
    check_eq("t6_kd_drop", kernel_done, 0);

    // Dropped last CTA with nothing in flight still completes the kernel.
    push(32, 9, 1'b1);
    tick();
    check_eq("t6_drop_kd0", kernel_done, 0);
    tick();
    check_eq("t6_drop_kd1", kernel_done, 1);
    check_eq("t6_drop_err", error, 1);

    // Reset while a CTA is being offered.
    cta_out_ready = '0;
    push(33, 1, 1'b0);
    expect_out("t6_send", 2, 33);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    tick();
    check_eq("mid_rst_c2", dut.u_credit_pool.credit[2], 8);
    check_eq("mid_rst_rdy", cta_in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
